// File: rtl/image_row_arbiter_if.sv
// Shared row-read bus between the image analysis engines, the arbiter and the row ROM.
// The arbiter takes the slave view; the engines plus ROM form the master side.
interface image_row_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) ();
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   lock_err;

  modport slave (
    input  req, req_addr, lock, mem_data,
    output gnt, mem_addr, rvalid, rdata, lock_err
  );

  modport master (
    output req, req_addr, lock, mem_data,
    input  gnt, mem_addr, rvalid, rdata, lock_err
  );
endinterface

// File: rtl/image_row_arbiter.sv
// Round-robin arbiter for the single image-ROM read port, with locked bursts,
// a lock timeout guard and a tag pipeline that routes returned rows to their requester.
module image_row_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 64
) (
  input logic Clk,
  input logic reset,
  image_row_arbiter_if.slave bus
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;
  localparam int TAG_W = RD_LAT * IDX_W;
  localparam int CNT_W = 8;

  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  owner, owner_nxt;
  logic [IDX_W-1:0]  win_idx, cand;
  logic [CNT_W-1:0]  lock_cnt, cnt_nxt, cur_cnt;
  logic              lock_err_q, lerr_nxt;
  logic              win_vld;
  logic [ADDR_W-1:0] last_addr, addr_sel;
  logic [RD_LAT-1:0] tag_vld;
  logic [TAG_W-1:0]  tag_idx;
  logic [IDX_W-1:0]  tag_head;
  int                rr_j;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Winner selection: only the owner while locked, otherwise first requester from ptr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    rr_j    = 0;
    if (!reset) begin
      if (state == ARB_LOCKED) begin
        win_vld = bus.req[owner];
        win_idx = owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          rr_j = int'(ptr) + k;
          if (rr_j >= NREQ) rr_j = rr_j - NREQ;
          cand = IDX_W'(rr_j);
          if (!win_vld && bus.req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
          end
        end
      end
    end
  end

  assign addr_sel = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];

  // cur_cnt is the ordinal of this cycle's grant within the current lock run.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    lerr_nxt  = lock_err_q;
    cur_cnt   = (state == ARB_LOCKED) ? lock_cnt + 1'b1 : CNT_W'(1);
    if (win_vld) begin
      if (bus.lock[win_idx] && cur_cnt != CNT_W'(MAX_LOCK)) begin
        state_nxt = ARB_LOCKED;
        owner_nxt = win_idx;
        cnt_nxt   = cur_cnt;
      end else begin
        // Plain grant, voluntary release, or a lock forcibly ended by timeout.
        state_nxt = ARB_OPEN;
        ptr_nxt   = wrap_inc(win_idx);
        cnt_nxt   = '0;
        if (bus.lock[win_idx]) lerr_nxt = 1'b1;
      end
    end else if (state == ARB_LOCKED) begin
      state_nxt = ARB_OPEN;
      ptr_nxt   = wrap_inc(owner);
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state      <= ARB_OPEN;
      ptr        <= '0;
      owner      <= '0;
      lock_cnt   <= '0;
      lock_err_q <= 1'b0;
      last_addr  <= '0;
      tag_vld    <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      lock_cnt   <= cnt_nxt;
      lock_err_q <= lerr_nxt;
      tag_vld    <= RD_LAT'({tag_vld, win_vld});
      if (win_vld) last_addr <= addr_sel;
    end
  end

  // NOTE: the tag index payload is left unreset; it is only ever read when its valid bit is set.
  always_ff @(posedge Clk) begin
    tag_idx <= TAG_W'({tag_idx, win_idx});
  end

  assign tag_head     = tag_idx[TAG_W-1 -: IDX_W];
  assign bus.gnt      = win_vld ? (NREQ'(1) << win_idx) : '0;
  assign bus.mem_addr = reset ? '0 : (win_vld ? addr_sel : last_addr);
  // Masking with reset drops a read already returning in the reset cycle.
  assign bus.rvalid   = (tag_vld[RD_LAT-1] && !reset) ? (NREQ'(1) << tag_head) : '0;
  assign bus.rdata    = bus.mem_data;
  assign bus.lock_err = lock_err_q;

endmodule

// File: tb/tb_image_row_arbiter.sv
// Bench for image_row_arbiter: one stimulus stream drives an RD_LAT=1 and an RD_LAT=2 instance,
// grants checked from a vector table, returned rows checked against a scoreboard queue.
module tb_image_row_arbiter;

  logic       Clk;
  logic       reset;
  logic [2:0] req_s;
  logic [2:0] lock_s;
  logic [5:0] a0_s, a1_s, a2_s;
  logic [63:0] rom_a, rom_b1, rom_b2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  image_row_arbiter_if #(.NREQ(3), .ADDR_W(6), .DATA_W(64)) bus_a ();
  image_row_arbiter_if #(.NREQ(3), .ADDR_W(6), .DATA_W(64)) bus_b ();

  image_row_arbiter #(.NREQ(3), .ADDR_W(6), .DATA_W(64), .RD_LAT(1), .MAX_LOCK(4)) dut_a (
    .Clk(Clk), .reset(reset), .bus(bus_a)
  );
  image_row_arbiter #(.NREQ(3), .ADDR_W(6), .DATA_W(64), .RD_LAT(2), .MAX_LOCK(4)) dut_b (
    .Clk(Clk), .reset(reset), .bus(bus_b)
  );

  function automatic logic [63:0] rom_row(input logic [5:0] a);
    return {8{{2'b10, a}}} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  assign bus_a.req      = req_s;
  assign bus_a.lock     = lock_s;
  assign bus_a.req_addr = {a2_s, a1_s, a0_s};
  assign bus_a.mem_data = rom_a;
  assign bus_b.req      = req_s;
  assign bus_b.lock     = lock_s;
  assign bus_b.req_addr = {a2_s, a1_s, a0_s};
  assign bus_b.mem_data = rom_b2;

  always_ff @(posedge Clk) begin
    rom_a  <= rom_row(bus_a.mem_addr);
    rom_b1 <= rom_row(bus_b.mem_addr);
    rom_b2 <= rom_b1;
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit         rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [5:0] a0, a1, a2;
    logic [2:0] gnt;
    logic [5:0] maddr;
    bit         lerr;
    bit         lchk;
  } vec_t;

  typedef struct {
    int         due;
    logic [2:0] idx;
    logic [5:0] addr;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_a[$];
  sb_t  sb_b[$];

  function automatic vec_t mk(bit rst, logic [2:0] rq, logic [2:0] lk, int a0, int a1, int a2,
                              logic [2:0] g, int ma, bit le, bit lc);
    vec_t v;
    v.rst   = rst;
    v.req   = rq;
    v.lock  = lk;
    v.a0    = 6'(a0);
    v.a1    = 6'(a1);
    v.a2    = 6'(a2);
    v.gnt   = g;
    v.maddr = 6'(ma);
    v.lerr  = le;
    v.lchk  = lc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    @(posedge Clk);
    #1;
    reset  = v.rst;
    req_s  = v.req;
    lock_s = v.lock;
    a0_s   = v.a0;
    a1_s   = v.a1;
    a2_s   = v.a2;
    @(negedge Clk);
    check({tag, " gnt_a"},   bus_a.gnt,      v.gnt);
    check({tag, " gnt_b"},   bus_b.gnt,      v.gnt);
    check({tag, " maddr_a"}, bus_a.mem_addr, v.maddr);
    check({tag, " maddr_b"}, bus_b.mem_addr, v.maddr);
    if (v.lchk) begin
      check({tag, " lerr_a"}, bus_a.lock_err, v.lerr);
      check({tag, " lerr_b"}, bus_b.lock_err, v.lerr);
    end
    if (v.rst) begin
      sb_a.delete();
      sb_b.delete();
    end
    if (sb_a.size() > 0 && sb_a[0].due == cyc) begin
      e = sb_a.pop_front();
      check({tag, " rvalid_a"}, bus_a.rvalid, e.idx);
      check({tag, " rdata_a"},  bus_a.rdata,  rom_row(e.addr));
    end else begin
      check({tag, " rvalid_a idle"}, bus_a.rvalid, 3'b000);
    end
    if (sb_b.size() > 0 && sb_b[0].due == cyc) begin
      e = sb_b.pop_front();
      check({tag, " rvalid_b"}, bus_b.rvalid, e.idx);
      check({tag, " rdata_b"},  bus_b.rdata,  rom_row(e.addr));
    end else begin
      check({tag, " rvalid_b idle"}, bus_b.rvalid, 3'b000);
    end
    if (!v.rst && v.gnt != 3'b000) begin
      e.idx  = v.gnt;
      e.addr = v.maddr;
      e.due  = cyc + 1;
      sb_a.push_back(e);
      e.due  = cyc + 2;
      sb_b.push_back(e);
    end
    cyc++;
  endtask

  initial begin
    reset  = 1'b1;
    req_s  = '0;
    lock_s = '0;
    a0_s   = '0;
    a1_s   = '0;
    a2_s   = '0;

    // Single requester, address held after the grant.
    vecs.push_back(mk(1, 3'b000, 3'b000,  0,  0,  0, 3'b000,  0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 3'b000,  0,  0,  0, 3'b000,  0, 0, 1));
    vecs.push_back(mk(0, 3'b001, 3'b000,  5,  0,  0, 3'b001,  5, 0, 1));
    vecs.push_back(mk(0, 3'b000, 3'b000,  0,  0,  0, 3'b000,  5, 0, 1));
    vecs.push_back(mk(0, 3'b000, 3'b000,  0,  0,  0, 3'b000,  5, 0, 1));
    // Round robin from a fresh pointer.
    vecs.push_back(mk(1, 3'b000, 3'b000,  0,  0,  0, 3'b000,  0, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000,  1,  2,  3, 3'b001,  1, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000,  1,  2,  3, 3'b010,  2, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000,  1,  2,  3, 3'b100,  3, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000,  4,  5,  6, 3'b001,  4, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000,  4,  5,  6, 3'b010,  5, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000,  4,  5,  6, 3'b100,  6, 0, 1));
    // Locked burst by requester 1, lock dropped on the 4th grant.
    vecs.push_back(mk(0, 3'b001, 3'b000,  7,  0,  0, 3'b001,  7, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b010, 20, 10, 30, 3'b010, 10, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b010, 20, 11, 30, 3'b010, 11, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b010, 20, 12, 30, 3'b010, 12, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000, 20, 13, 30, 3'b010, 13, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000, 20, 14, 30, 3'b100, 30, 0, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000, 20, 14, 30, 3'b001, 20, 0, 1));
    // Timeout: requester 2 keeps lock high past MAX_LOCK=4 grants.
    vecs.push_back(mk(0, 3'b101, 3'b100, 41,  0, 40, 3'b100, 40, 0, 1));
    vecs.push_back(mk(0, 3'b101, 3'b100, 41,  0, 41, 3'b100, 41, 0, 1));
    vecs.push_back(mk(0, 3'b101, 3'b100, 41,  0, 42, 3'b100, 42, 0, 1));
    vecs.push_back(mk(0, 3'b101, 3'b100, 41,  0, 43, 3'b100, 43, 0, 1));
    vecs.push_back(mk(0, 3'b101, 3'b100, 50,  0, 44, 3'b001, 50, 1, 1));
    vecs.push_back(mk(0, 3'b101, 3'b100, 50,  0, 44, 3'b100, 44, 1, 1));
    // Owner withdraws its request: lock released without a grant.
    vecs.push_back(mk(0, 3'b000, 3'b100,  0,  0,  0, 3'b000, 44, 1, 1));
    vecs.push_back(mk(0, 3'b111, 3'b000, 51, 52, 53, 3'b001, 51, 1, 1));
    // Reset the cycle after a grant: the in-flight read never returns.
    vecs.push_back(mk(1, 3'b111, 3'b000, 51, 52, 53, 3'b000,  0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 3'b000, 60, 61, 62, 3'b001, 60, 0, 1));
    vecs.push_back(mk(0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 60, 0, 1));
    vecs.push_back(mk(0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 60, 0, 1));
    // Two back-to-back grants, returns at t+1 and t+2 depending on latency.
    vecs.push_back(mk(1, 3'b000, 3'b000,  0,  0,  0, 3'b000,  0, 0, 1));
    vecs.push_back(mk(0, 3'b011, 3'b000, 33, 34,  0, 3'b001, 33, 0, 1));
    vecs.push_back(mk(0, 3'b011, 3'b000, 33, 34,  0, 3'b010, 34, 0, 1));
    vecs.push_back(mk(0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 34, 0, 1));
    vecs.push_back(mk(0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 34, 0, 1));
    vecs.push_back(mk(0, 3'b000, 3'b000,  0,  0,  0, 3'b000, 34, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Sustained stream: requester 2 alone, new address every cycle.
    for (int k = 0; k < 8; k++) begin
      apply(mk(0, 3'b100, 3'b000, 0, 0, 16 + k, 3'b100, 16 + k, 0, 1), $sformatf("stream%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b000, 23, 0, 1), $sformatf("drain%0d", k));
    end

    check("scoreboard_a drained", 64'(sb_a.size()), 64'd0);
    check("scoreboard_b drained", 64'(sb_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
